// File: rtl/chi_intf.sv
// Shared CHI link definitions: response flit layout, RSP opcodes and the
// link-layer state encoding used by the HN-F transmit channels.
package chi_intf;

  typedef logic [4:0] rsp_opc_t;

  localparam rsp_opc_t RSP_OPC_LCRDRETURN   = 5'h00;
  localparam rsp_opc_t RSP_OPC_COMP         = 5'h04;
  localparam rsp_opc_t RSP_OPC_COMPDBIDRESP = 5'h05;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgtid;
    logic [10:0] srcid;
    logic [11:0] txnid;
    rsp_opc_t    opcode;
    logic [1:0]  resperr;
    logic [2:0]  resp;
    logic [2:0]  fwdstate;
    logic [11:0] dbid;
    logic [3:0]  pcrdtype;
    logic        tracetag;
  } rspflit_t;

  localparam int RSPFLIT_W = $bits(rspflit_t);

  typedef enum logic [1:0] {
    LINK_STOP   = 2'd0,
    LINK_RUN    = 2'd1,
    LINK_DRAIN  = 2'd2,
    LINK_RETURN = 2'd3
  } link_state_e;

  // Flit that hands one L-credit back to the receiver: opcode only.
  function automatic rspflit_t lcrd_return_flit();
    rspflit_t f;
    f        = {RSPFLIT_W{1'b0}};
    f.opcode = RSP_OPC_LCRDRETURN;
    return f;
  endfunction

endpackage

// File: rtl/hnf_txrsp_if.sv
// Response path bundle between the HN-F core, the TXRSP link block and the
// link receiver.
interface hnf_txrsp_if;
  import chi_intf::*;

  rspflit_t rsp_in;
  logic     rsp_in_v;
  logic     rsp_in_ready;
  rspflit_t txrspflit;
  logic     txrspflitv;
  logic     txrspflitpend;
  logic     txrsplcrdv;

  modport slave (
    input  rsp_in, rsp_in_v, txrsplcrdv,
    output rsp_in_ready, txrspflit, txrspflitv, txrspflitpend
  );

  modport master (
    output rsp_in, rsp_in_v, txrsplcrdv,
    input  rsp_in_ready, txrspflit, txrspflitv, txrspflitpend
  );

endinterface

// File: rtl/chi_flit_fifo.sv
// Small synchronous flit FIFO with a combinational head; DEPTH must be a
// power of two so the pointers wrap by plain overflow.
module chi_flit_fifo #(
  parameter type flit_t = logic [7:0],
  parameter int  DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  flit_t                    push_data,
  input  logic                     pop,
  output flit_t                    head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  flit_t              mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hnf_txrsp.sv
// HN-F TXRSP link-layer transmitter: buffers core responses, spends L-credits
// to send them, and returns unused credits as LCrdReturn flits on deactivation.
module hnf_txrsp
  import chi_intf::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LCRD   = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            link_en,
  hnf_txrsp_if.slave      bus,
  output logic            link_stopped,
  output logic            lcrd_ovf
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LCRD_W = $clog2(MAX_LCRD + 1);

  localparam logic [1:0] ST_STOP   = LINK_STOP;
  localparam logic [1:0] ST_RUN    = LINK_RUN;
  localparam logic [1:0] ST_DRAIN  = LINK_DRAIN;
  localparam logic [1:0] ST_RETURN = LINK_RETURN;

  localparam logic [LCRD_W-1:0] LCRD_ZERO = {LCRD_W{1'b0}};
  localparam logic [LCRD_W-1:0] LCRD_ONE  = LCRD_W'(1);
  localparam logic [LCRD_W-1:0] LCRD_MAX  = LCRD_W'(MAX_LCRD);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [LCRD_W-1:0] credit_r;
  logic [LCRD_W-1:0] credit_nxt_s;
  logic              ovf_r;
  logic              ovf_nxt_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [CNT_W-1:0]  fifo_cnt_nxt_s;
  rspflit_t          fifo_head_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              send_s;
  logic              pend_nxt_s;
  rspflit_t          flit_nxt_s;
  rspflit_t          flit_r;
  logic              flitv_r;
  logic              pend_r;

  // One shared send rule, so pend (evaluated on next-state values) always
  // matches the send decision made in the following cycle.
  function automatic logic send_ok(
    input logic [1:0]        st,
    input logic [CNT_W-1:0]  cnt,
    input logic [LCRD_W-1:0] cred
  );
    logic has_cred;
    has_cred = (cred != LCRD_ZERO);
    if ((st == ST_RUN) || (st == ST_DRAIN)) begin
      return has_cred && (cnt != {CNT_W{1'b0}});
    end else if (st == ST_RETURN) begin
      return has_cred;
    end else begin
      return 1'b0;
    end
  endfunction

  chi_flit_fifo #(
    .flit_t (rspflit_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (bus.rsp_in),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_cnt_s)
  );

  assign ready_s = (state_r == ST_RUN) && !fifo_full_s;
  assign push_s  = bus.rsp_in_v && ready_s;
  assign send_s  = send_ok(state_r, fifo_cnt_s, credit_r);
  assign pop_s   = send_s && (state_r != ST_RETURN);

  // Link state machine; RETURN waits for the last LCrdReturn to leave.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_STOP:   if (link_en) state_nxt_s = ST_RUN;   else state_nxt_s = ST_STOP;
      ST_RUN:    if (!link_en) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_RUN;
      ST_DRAIN:  if (fifo_empty_s) state_nxt_s = ST_RETURN; else state_nxt_s = ST_DRAIN;
      ST_RETURN: begin
        if ((credit_r == LCRD_ZERO) && !flitv_r) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_RETURN;
        end
      end
      default:   state_nxt_s = ST_STOP;
    endcase
  end

  // Credit count: grant and spend in the same cycle cancel; saturate at max.
  always_comb begin
    credit_nxt_s = credit_r;
    ovf_nxt_s    = ovf_r;
    case ({bus.txrsplcrdv, send_s})
      2'b10: begin
        if (credit_r == LCRD_MAX) begin
          ovf_nxt_s = 1'b1;
        end else begin
          credit_nxt_s = credit_r + LCRD_ONE;
        end
      end
      2'b01:   credit_nxt_s = credit_r - LCRD_ONE;
      default: credit_nxt_s = credit_r;
    endcase
  end

  // Occupancy the FIFO will hold after this edge, for the pend lookahead.
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_s;
    if (push_s && !pop_s) begin
      fifo_cnt_nxt_s = fifo_cnt_s + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      fifo_cnt_nxt_s = fifo_cnt_s - CNT_W'(1);
    end else begin
      fifo_cnt_nxt_s = fifo_cnt_s;
    end
  end

  // Next flit on the wire: FIFO head, a credit return, or all zeros when idle.
  always_comb begin
    flit_nxt_s = {RSPFLIT_W{1'b0}};
    pend_nxt_s = send_ok(state_nxt_s, fifo_cnt_nxt_s, credit_nxt_s);
    if (!send_s) begin
      flit_nxt_s = {RSPFLIT_W{1'b0}};
    end else if (state_r == ST_RETURN) begin
      flit_nxt_s = lcrd_return_flit();
    end else begin
      flit_nxt_s = fifo_head_s;
    end
  end

  // State, credits and registered channel outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= ST_STOP;
      credit_r <= LCRD_ZERO;
      ovf_r    <= 1'b0;
      flitv_r  <= 1'b0;
      pend_r   <= 1'b0;
      flit_r   <= {RSPFLIT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      ovf_r    <= ovf_nxt_s;
      flitv_r  <= send_s;
      pend_r   <= pend_nxt_s;
      flit_r   <= flit_nxt_s;
    end
  end

  assign bus.rsp_in_ready  = ready_s;
  assign bus.txrspflit     = flit_r;
  assign bus.txrspflitv    = flitv_r;
  assign bus.txrspflitpend = pend_r;
  assign link_stopped      = (state_r == ST_STOP);
  assign lcrd_ovf          = ovf_r;

endmodule

// File: tb/tb_hnf_txrsp.sv
// Directed bench for hnf_txrsp: credit flow, back-pressure, drain/credit
// return, overflow flag and mid-operation reset.
module tb_hnf_txrsp;
  import chi_intf::*;

  logic clock = 1'b0;
  logic reset;
  logic link_en;
  logic link_stopped;
  logic lcrd_ovf;

  hnf_txrsp_if bus();

  hnf_txrsp #(.FIFO_DEPTH(4), .MAX_LCRD(15)) dut (
    .clock        (clock),
    .reset        (reset),
    .link_en      (link_en),
    .bus          (bus),
    .link_stopped (link_stopped),
    .lcrd_ovf     (lcrd_ovf)
  );

  always #5 clock = ~clock;

  int       n_checks = 0;
  int       n_fail   = 0;
  rspflit_t got[$];
  logic     pend_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic rspflit_t mk(input logic [11:0] id);
    rspflit_t f;
    f        = '0;
    f.txnid  = id;
    f.opcode = (id[0]) ? RSP_OPC_COMPDBIDRESP : RSP_OPC_COMP;
    f.srcid  = 11'd3;
    f.dbid   = id;
    return f;
  endfunction

  task automatic enqueue(input logic [11:0] id);
    bus.rsp_in   = mk(id);
    bus.rsp_in_v = 1'b1;
    check_eq("enq_ready", 64'(bus.rsp_in_ready), 64'd1);
    step();
    bus.rsp_in_v = 1'b0;
  endtask

  task automatic credits(input int n);
    bus.txrsplcrdv = 1'b1;
    repeat (n) step();
    bus.txrsplcrdv = 1'b0;
  endtask

  // Channel monitor: every flit must be announced by pend, idle flit is zero.
  always @(negedge clock) begin
    if (bus.txrspflitv === 1'b1) begin
      check_eq("pend_before_flitv", 64'(pend_prev), 64'd1);
      got.push_back(bus.txrspflit);
    end else begin
      check_eq("flit_idle_zero", 64'(|bus.txrspflit), 64'd0);
    end
    pend_prev = bus.txrspflitpend;
  end

  initial begin
    reset          = 1'b0;
    link_en        = 1'b0;
    bus.rsp_in     = '0;
    bus.rsp_in_v   = 1'b0;
    bus.txrsplcrdv = 1'b0;
    step();
    step();
    check_eq("rst_flitv",   64'(bus.txrspflitv),    64'd0);
    check_eq("rst_pend",    64'(bus.txrspflitpend), 64'd0);
    check_eq("rst_flit",    64'(|bus.txrspflit),    64'd0);
    check_eq("rst_ready",   64'(bus.rsp_in_ready),  64'd0);
    check_eq("rst_stopped", 64'(link_stopped),      64'd1);
    check_eq("rst_ovf",     64'(lcrd_ovf),          64'd0);
    check_eq("rst_credit",  64'(dut.credit_r),      64'd0);
    check_eq("rst_occ",     64'(dut.u_fifo.count_r), 64'd0);

    // Three credits, then three flits leave in order.
    reset   = 1'b1;
    link_en = 1'b1;
    step();
    check_eq("s1_stopped", 64'(link_stopped), 64'd0);
    credits(3);
    check_eq("s1_credit3", 64'(dut.credit_r), 64'd3);
    got.delete();
    for (int i = 0; i < 3; i++) enqueue(12'(5 + i));
    repeat (5) step();
    check_eq("s1_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("s1_order%0d", i),
               (i < got.size()) ? 64'(got[i].txnid) : 64'hdead, 64'(5 + i));
    end
    check_eq("s1_credit0", 64'(dut.credit_r), 64'd0);

    // No credits: FIFO fills, then one grant releases exactly one flit.
    got.delete();
    for (int i = 0; i < 4; i++) enqueue(12'(10 + i));
    check_eq("s2_ready_full", 64'(bus.rsp_in_ready), 64'd0);
    check_eq("s2_occ4", 64'(dut.u_fifo.count_r), 64'd4);
    repeat (3) step();
    check_eq("s2_no_flit", 64'(got.size()), 64'd0);
    bus.txrsplcrdv = 1'b1;
    step();
    bus.txrsplcrdv = 1'b0;
    check_eq("s2_flitv_n1", 64'(bus.txrspflitv), 64'd0);
    check_eq("s2_pend_n1",  64'(bus.txrspflitpend), 64'd1);
    step();
    check_eq("s2_flitv_n2", 64'(bus.txrspflitv), 64'd1);
    check_eq("s2_txnid",    64'(bus.txrspflit.txnid), 64'd10);
    step();
    check_eq("s2_flitv_n3", 64'(bus.txrspflitv), 64'd0);
    check_eq("s2_ready_again", 64'(bus.rsp_in_ready), 64'd1);
    check_eq("s2_one_flit", 64'(got.size()), 64'd1);

    // Grant coincident with a send keeps the count at 1.
    got.delete();
    bus.txrsplcrdv = 1'b1;
    step();
    check_eq("s3_credit1", 64'(dut.credit_r), 64'd1);
    step();
    bus.txrsplcrdv = 1'b0;
    check_eq("s3_flitv_a", 64'(bus.txrspflitv), 64'd1);
    check_eq("s3_txnid_a", 64'(bus.txrspflit.txnid), 64'd11);
    check_eq("s3_credit_hold", 64'(dut.credit_r), 64'd1);
    step();
    check_eq("s3_flitv_b", 64'(bus.txrspflitv), 64'd1);
    check_eq("s3_txnid_b", 64'(bus.txrspflit.txnid), 64'd12);
    check_eq("s3_credit0", 64'(dut.credit_r), 64'd0);
    step();
    check_eq("s3_idle", 64'(bus.txrspflitv), 64'd0);

    // Reset with three flits queued discards them.
    got.delete();
    enqueue(12'd14);
    enqueue(12'd15);
    check_eq("s6_occ3", 64'(dut.u_fifo.count_r), 64'd3);
    reset = 1'b0;
    step();
    check_eq("s6_flitv",   64'(bus.txrspflitv),    64'd0);
    check_eq("s6_ready",   64'(bus.rsp_in_ready),  64'd0);
    check_eq("s6_occ0",    64'(dut.u_fifo.count_r), 64'd0);
    check_eq("s6_credit0", 64'(dut.credit_r),      64'd0);
    reset   = 1'b1;
    link_en = 1'b0;
    repeat (3) step();
    check_eq("s6_no_flit", 64'(got.size()), 64'd0);

    // Credits in STOP are held; the 16th grant saturates and flags overflow.
    credits(15);
    check_eq("s4_credit15", 64'(dut.credit_r), 64'd15);
    check_eq("s4_ovf_clear", 64'(lcrd_ovf), 64'd0);
    credits(1);
    check_eq("s4_credit_sat", 64'(dut.credit_r), 64'd15);
    check_eq("s4_ovf_set", 64'(lcrd_ovf), 64'd1);
    repeat (3) step();
    check_eq("s4_ovf_sticky", 64'(lcrd_ovf), 64'd1);
    check_eq("s4_stopped", 64'(link_stopped), 64'd1);
    reset = 1'b0;
    step();
    check_eq("s4_ovf_rst", 64'(lcrd_ovf), 64'd0);
    reset = 1'b1;

    // Deactivation: drain two flits, return the three spare credits.
    link_en = 1'b1;
    step();
    enqueue(12'd20);
    enqueue(12'd21);
    link_en = 1'b0;
    step();
    check_eq("s5_draining", 64'(link_stopped), 64'd0);
    got.delete();
    credits(5);
    repeat (10) step();
    check_eq("s5_count", 64'(got.size()), 64'd5);
    check_eq("s5_txnid0", (got.size() > 0) ? 64'(got[0].txnid) : 64'hdead, 64'd20);
    check_eq("s5_txnid1", (got.size() > 1) ? 64'(got[1].txnid) : 64'hdead, 64'd21);
    for (int i = 2; i < 5; i++) begin
      check_eq($sformatf("s5_lcrdret%0d", i),
               (i < got.size()) ? 64'(|got[i]) : 64'hdead, 64'd0);
    end
    check_eq("s5_stopped", 64'(link_stopped), 64'd1);
    check_eq("s5_credit0", 64'(dut.credit_r), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
